// File: rtl/recip_q16_16.sv
// Iterative Q4.28 -> Q16.16 reciprocal: 2^SHIFT / |det| by restoring division, one quotient bit
// per cycle, with zero-determinant and saturation flags for the 2x2 inverter's start/done handshake.
module recip_q16_16 #(
  parameter int DET_W = 32,
  parameter int REC_W = 32,
  parameter int SHIFT = 44
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [DET_W-1:0] det,
  output logic signed [REC_W-1:0] inv_det,
  output logic                    done,
  output logic                    busy,
  output logic                    error,
  output logic                    sat
);

  localparam int CNT_W = $clog2(REC_W);
  localparam logic [DET_W:0] ONE      = {{DET_W{1'b0}}, 1'b1};
  // Numerator bits above REC_W contribute only 2^(SHIFT-REC_W) to the remainder, since M is
  // always larger than that on the division path.
  localparam logic [DET_W:0] REM_INIT = ONE << (SHIFT - REC_W);
  localparam logic [DET_W:0] SAT_LIM  = ONE << (SHIFT - REC_W + 1);

  typedef enum logic [1:0] {IDLE, SETUP, DIV, FIN} state_t;

  state_t                    state_q, state_d;
  logic signed [DET_W-1:0]   det_q, det_d;
  logic                      neg_q, neg_d;
  logic        [DET_W:0]     mag_q, mag_d;
  logic        [DET_W:0]     rem_q, rem_d;
  logic        [REC_W-1:0]   quo_q, quo_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [REC_W-1:0]   inv_q, inv_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      sat_q, sat_d;

  logic        [DET_W:0]     mag_c;
  logic        [DET_W:0]     trial_c;

  function automatic logic signed [REC_W-1:0] sat_value(input logic neg);
    return neg ? {1'b1, {(REC_W-1){1'b0}}} : {1'b0, {(REC_W-1){1'b1}}};
  endfunction

  function automatic logic signed [REC_W-1:0] apply_sign(input logic [REC_W-1:0] q,
                                                         input logic neg);
    return neg ? $signed(REC_W'(0) - q) : $signed(q);
  endfunction

  assign mag_c   = det_q[DET_W-1] ? ((DET_W+1)'(0) - {det_q[DET_W-1], det_q})
                                  : {1'b0, det_q};
  assign trial_c = rem_q << 1;

  always_comb begin
    state_d = state_q;
    det_d   = det_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    inv_d   = inv_q;
    done_d  = 1'b0;
    err_d   = err_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        // The done cycle doubles as the mandatory idle gap between requests.
        if (start && !done_q) begin
          det_d   = det;
          err_d   = 1'b0;
          sat_d   = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        neg_d = det_q[DET_W-1];
        mag_d = mag_c;
        if (mag_c == '0) begin
          err_d   = 1'b1;
          inv_d   = '0;
          state_d = FIN;
        end else if ((!det_q[DET_W-1] && mag_c <= SAT_LIM) ||
                     ( det_q[DET_W-1] && mag_c <  SAT_LIM)) begin
          sat_d   = 1'b1;
          inv_d   = sat_value(det_q[DET_W-1]);
          state_d = FIN;
        end else begin
          rem_d   = REM_INIT;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        if (trial_c >= mag_q) begin
          rem_d = trial_c - mag_q;
          quo_d = {quo_q[REC_W-2:0], 1'b1};
        end else begin
          rem_d = trial_c;
          quo_d = {quo_q[REC_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(REC_W - 1)) state_d = FIN;
      end
      FIN: begin
        if (!err_q && !sat_q) inv_d = apply_sign(quo_q, neg_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      det_q   <= '0;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      inv_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      det_q   <= det_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
    end
  end

  assign inv_det = inv_q;
  assign done    = done_q;
  assign busy    = (state_q != IDLE) || done_q;
  assign error   = err_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_recip_q16_16.sv
// Scoreboard bench for recip_q16_16: expected reciprocal, flags and latency are queued at
// issue time from a 64-bit arithmetic model and compared when done appears.
module tb_recip_q16_16;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic signed [31:0] det;
  logic signed [31:0] inv_det;
  logic               done, busy, error, sat;

  typedef struct packed {
    logic [31:0] inv;
    logic        err;
    logic        sat;
    logic [31:0] lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  recip_q16_16 #(.DET_W(32), .REC_W(32), .SHIFT(44)) dut (
    .clk(clk), .reset(reset), .start(start), .det(det),
    .inv_det(inv_det), .done(done), .busy(busy), .error(error), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] d);
    exp_t   e;
    longint sd, m, q;
    sd    = longint'($signed(d));
    m     = (sd < 0) ? -sd : sd;
    e.err = 1'b0;
    e.sat = 1'b0;
    e.lat = 32'd34;
    e.inv = 32'h0;
    if (m == 0) begin
      e.err = 1'b1;
      e.lat = 32'd2;
    end else begin
      q = (longint'(1) << 44) / m;
      if (sd > 0 && q > 64'sh7FFF_FFFF) begin
        e.sat = 1'b1; e.inv = 32'h7FFF_FFFF; e.lat = 32'd2;
      end else if (sd < 0 && q > 64'sh8000_0000) begin
        e.sat = 1'b1; e.inv = 32'h8000_0000; e.lat = 32'd2;
      end else begin
        e.inv = (sd < 0) ? 32'(-q) : 32'(q);
      end
    end
    return e;
  endfunction

  task automatic run_req(input logic [31:0] d, input bit poke);
    exp_t e;
    bit   seen;
    int   k;
    int   extra;
    @(negedge clk);
    det   = d;
    start = 1'b1;
    sb.push_back(model(d));
    @(posedge clk);
    #1;
    check("busy_at_accept", busy, 1);
    start = 1'b0;
    det   = $urandom;
    seen  = 0;
    k     = 0;
    while (!seen && k < 60) begin
      @(posedge clk);
      k++;
      #1;
      if (done) seen = 1;
      else if (poke && k >= 8 && k <= 12) begin
        start = 1'b1;
        det   = 32'h0000_0007;
      end else start = 1'b0;
    end
    start = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(k), e.lat);
      check("inv_det", inv_det, e.inv);
      check("error", error, e.err);
      check("sat", sat, e.sat);
      check("busy_in_done", busy, 1);
      @(posedge clk);
      #1;
      check("done_width", done, 0);
      check("busy_after", busy, 0);
      check("inv_held", inv_det, e.inv);
      if (poke) begin
        extra = 0;
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          if (done) extra++;
        end
        check("extra_done", 32'(extra), 0);
      end
    end
  endtask

  initial begin
    int ndone;
    reset = 1'b0;
    start = 1'b1;
    det   = 32'h1000_0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_inv", inv_det, 0);
      check("rst_flags", {error, sat}, 0);
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_done", done, 0);

    run_req(32'h1000_0000, 0);
    run_req(32'hF800_0000, 0);
    run_req(32'h3000_0000, 0);
    run_req(32'h0000_0000, 0);
    run_req(32'h1000_0000, 0);
    run_req(32'h0000_2000, 0);
    run_req(32'hFFFF_E000, 0);
    run_req(32'h8000_0000, 0);
    run_req(32'h0000_2001, 0);
    run_req(32'hFFFF_E001, 0);
    run_req(32'hFFFF_DFFF, 0);
    run_req(32'h7FFF_FFFF, 0);
    run_req(32'h3000_0000, 1);

    // Abort a division in progress
    run_req(32'h1000_0000, 0);
    @(negedge clk);
    det   = 32'h0800_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_inv", inv_det, 0);
    check("abort_flags", {error, sat}, 0);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 0);
    run_req(32'hF800_0000, 0);

    for (int i = 0; i < 6; i++) run_req($urandom, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/recip_q16_16.md
Name: recip_q16_16

Overview:
- Iterative fixed-point reciprocal unit; the responder side of the matrix inverter's start/done handshake.
- Takes the Q4.28 determinant from the 2x2 inverter, computes inv_det = 1/det in Q16.16, and returns it with a one-cycle done pulse.
- The inverter's INV state waits on done. Zero and out-of-range determinants are flagged so the inverter can raise its error output.

Parameters:
- DET_W, 32, determinant width (Q4.28: 4 integer bits including sign, 28 fraction bits).
- REC_W, 32, result width (Q16.16: 16 integer bits including sign, 16 fraction bits).
- SHIFT, 44, numerator exponent; recip = 2^SHIFT / det_raw (28 + 16).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clk, clears all state when 0.
- start  input  1  request pulse from the inverter; accepted only in IDLE.
- det  input  32  signed Q4.28 determinant, sampled on the accepting edge.
- inv_det  output  32  signed Q16.16 reciprocal, held until the next accepted start.
- done  output  1  one-cycle pulse; inv_det, error and sat are valid in that cycle and after it.
- busy  output  1  high from acceptance until the cycle done is high, inclusive.
- error  output  1  det was zero; inv_det = 0.
- sat  output  1  result clipped to the Q16.16 range.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE; inv_det=0, done=0, busy=0, error=0, sat=0. Takes effect from any state and aborts any division in progress. No done is issued for an aborted request.
- States: IDLE, SETUP, DIV, FIN.
- IDLE: if start=1, capture det and go to SETUP. busy rises on that edge.
- SETUP (1 cycle):
  - Compute sign and 33-bit magnitude M=|det|; det=0x80000000 gives M=2^31, no overflow.
  - If M=0: error=1, inv_det=0, go to FIN.
  - Else if positive and M<=8192, or negative and M<=8191: sat=1, inv_det=0x7FFFFFFF or 0x80000000, go to FIN.
  - Otherwise go to DIV.
- DIV (exactly 32 cycles): restoring division of 2^44 by M, one quotient bit per cycle, MSB (bit 31) first. Quotient Q=floor(2^44/M), truncated toward zero. Remainder register is at least 33 bits.
- FIN (1 cycle):
  - On the division path, load inv_det with Q, or -Q if det was negative (two's complement, 32 bits).
  - Assert done=1 for exactly this cycle. busy=1 in this cycle, then 0.
  - Return to IDLE.
- Latency, counting the accepting edge as edge 0:
  - Division path: done high in the cycle after edge 34.
  - Zero/sat path: done high in the cycle after edge 2.
- error and sat are cleared on every accepted start, updated in SETUP, and never both 1.
- start while busy=1 is ignored, with no queuing. start held high continuously re-triggers only from IDLE, so back-to-back requests are spaced by the full latency plus one IDLE cycle.
- det is sampled only at acceptance; changes during busy have no effect.
- Negative boundary: M=8192, negative gives Q=2^31, output 0x80000000 exactly, sat=0.

Test Plan:
- Reset held low 3 cycles with start=1 -> outputs all 0, busy=0, no done; release, det=0x10000000 (1.0), start pulse -> done in the cycle after edge 34, inv_det=0x00010000, error=0, sat=0.
- det=0xF8000000 (-0.5) -> inv_det=0xFFFE0000 (-2.0); det=0x30000000 (3.0) -> inv_det=0x00005555 (truncated 0.33333).
- det=0 -> done in the cycle after edge 2, error=1, sat=0, inv_det=0x00000000; next request det=0x10000000 -> error returns to 0.
- det=0x00002000 (+8192) -> sat=1, inv_det=0x7FFFFFFF at latency 2; det=0xFFFFE000 (-8192) -> sat=0, inv_det=0x80000000 at latency 34; det=0x80000000 (-8.0) -> inv_det=0xFFFFE000 (-0.125).
- Second start and a det change issued mid-DIV -> ignored, result matches the first det, exactly one done pulse.
- reset=0 asserted at DIV cycle 10 -> IDLE next cycle, no done, outputs 0; a new start after release completes normally.
